countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   mm:ss countdown timer for the DE-series board; counterpart to the stopwatch (counts down, not up).
//   Loads a BCD preset from SW, counts down once per second on start, stops at 00:00, flags expiry.
//   Drives four active-low seven-segment displays and one LED; keys are raw active-low push buttons.
// PARAMETERS
//   TICK_DIV   50_000_000  CLOCK_50 cycles per countdown step (1 s at 50 MHz)
//   BLINK_DIV  12_500_000  cycles per blink half-period in DONE (COUNTDOWN_BLINK_EN only)
// PORTS
//   CLOCK_50  in   1   system clock; all state on rising edge
//   RESET_N   in   1   asynchronous active-low reset
//   KEY       in   2   raw buttons, low = pressed; [0] load, [1] start/pause/ack
//   SW        in   16  preset BCD {min_tens, min_units, sec_tens, sec_units}
//   HEX0      out  [0:6]  sec units, segments a..g, active-low
//   HEX1      out  [0:6]  sec tens
//   HEX2      out  [0:6]  min units
//   HEX3      out  [0:6]  min tens
//   LEDR      out  1   expired flag, high in DONE
// BEHAVIOUR
//   Reset: state IDLE, all digits 0, prescaler 0, LEDR 0, HEX0..3 = 7'b0000001 ("0").
//   Keys: 2-flop synchroniser per KEY, then falling-edge detect -> 1-cycle press pulse; a press
//     acts on the 3rd rising edge after KEY falls. Holding a key gives exactly one pulse.
//   Load (KEY[0] pulse, any state): digits <= clamped SW; prescaler <= 0; LEDR <= 0; state IDLE.
//     Clamp: tens digits >5 -> 5, units digits >9 -> 9 (range 00:00..59:59).
//   KEY[1] pulse: IDLE->RUN if digits != 00:00 (prescaler <= 0), else stay IDLE;
//     RUN->PAUSE; PAUSE->RUN; DONE->IDLE (LEDR <= 0, digits stay 00:00).
//   Same-cycle KEY[0] and KEY[1] pulses: load wins, KEY[1] ignored.
//   RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and value decrements by 1 s
//     in that same cycle.
//   Decrement: sec_units 0->9 with borrow, else -1; sec_tens 0->5 with borrow; min_units 0->9
//     with borrow; min_tens -1. 00:00 never wraps to 59:59.
//   Decrement yielding 00:00: state DONE and LEDR 1 from the next edge; no further ticks.
//   PAUSE: prescaler and digits frozen (not cleared); resume continues mid-second.
//   HEX: combinational decode of registered digits, zero added latency; digits 0-9 only
//     (0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//     8=0000000 9=0000100).
//   RESET_N low mid-count: immediate asynchronous return to reset values, whatever the state.
// CONFIGURATION
//   COUNTDOWN_BLINK_EN defined: in DONE, HEX0..3 alternate "00:00" and blank (7'b1111111) every
//     BLINK_DIV cycles; blink counter cleared on entering DONE, first half shows digits.
//   Undefined: DONE shows steady 00:00; BLINK_DIV unused, no blink counter.
//   LEDR unaffected either way.
// STRUCTURE
//   Package countdown_pkg: state enum {IDLE, RUN, PAUSE, DONE}, BCD digit type (4 bit),
//     segment constants SEG_0..SEG_9, SEG_BLANK, clamp limits (5, 9).
//   Sub-module bcd_down_digit: one digit, inputs dec_en, max value (5 or 9); outputs next value
//     and borrow; instantiated four times as a borrow chain.
//   Synchroniser, edge detect, prescaler, FSM and segment decode stay in the top module.
// TESTING  (bench uses TICK_DIV=10, BLINK_DIV=4)
//   1 Reset: RESET_N low -> HEX0..3 = 0000001, LEDR 0; KEY[1] press in IDLE at 00:00 -> stays IDLE.
//   2 SW=16'h0012, press KEY0 then KEY1 -> value 00:11 after 10 cycles, 00:00 after 120, LEDR 1.
//   3 Borrow chain: SW=16'h1000, start -> 09:59 after first tick; SW=16'h0100 -> 00:59.
//   4 Pause: start 00:05, KEY1 at prescaler=6, hold 50 cycles -> value and prescaler frozen;
//     KEY1 again -> next decrement 4 cycles later.
//   5 Clamp + collision: SW=16'h7A8F, KEY0 and KEY1 pulse same cycle -> 59:59 loaded, state IDLE.
//   6 Async reset in RUN at 00:37 -> outputs reset before the next clock edge; with
//     COUNTDOWN_BLINK_EN, DONE shows 0000001 for 4 cycles, 1111111 for 4 cycles, repeating.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown timer: FSM states, BCD digit type,
// active-low seven-segment patterns (segments a..g, a leftmost) and digit clamp limits.
package countdown_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t TENS_MAX  = 4'd5;
   localparam bcd_t UNITS_MAX = 4'd9;

   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   function automatic logic [0:6] seg_decode(input bcd_t d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counting chain: decrements when enabled, wrapping 0 -> max_i
// and raising borrow_o so the next-higher digit decrements in the same cycle.
module bcd_down_digit
   import countdown_pkg::*;
(
   input  bcd_t value_i,
   input  logic dec_en_i,
   input  bcd_t max_i,
   output bcd_t next_o,
   output logic borrow_o
);

   always_comb begin
      borrow_o = dec_en_i && (value_i == 4'd0);
      if (!dec_en_i)
         next_o = value_i;
      else if (value_i == 4'd0)
         next_o = max_i;
      else
         next_o = value_i - 4'd1;
   end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer: BCD preset load, 1 Hz countdown with pause, expiry flag on LEDR.
// Define COUNTDOWN_BLINK_EN to blink the 00:00 display while expired.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned BLINK_DIV = 12_500_000
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [1:0]  KEY,
   input  logic [15:0] SW,
   output logic [0:6]  HEX0,
   output logic [0:6]  HEX1,
   output logic [0:6]  HEX2,
   output logic [0:6]  HEX3,
   output logic        LEDR
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   logic [1:0] key_meta_q, key_sync_q, key_prev_q;
   logic [1:0] press;

   state_e          state_q;
   logic [3:0][3:0] digit_q;     // [0] sec units .. [3] min tens
   logic [3:0][3:0] digit_d;
   logic [3:0][3:0] sw_clamped;
   logic [PW-1:0]   presc_q;
   logic            led_q;
   logic            tick;
   logic [2:0]      borrow;
   logic            unused_top_borrow;

   // NOTE: synchroniser flops reset to 1 (released) so reset deassertion never fakes a press.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_meta_q <= 2'b11;
         key_sync_q <= 2'b11;
         key_prev_q <= 2'b11;
      end else begin
         key_meta_q <= KEY;
         key_sync_q <= key_meta_q;
         key_prev_q <= key_sync_q;
      end
   end

   assign press = key_prev_q & ~key_sync_q;

   always_comb begin
      sw_clamped[0] = clamp_digit(SW[3:0],   UNITS_MAX);
      sw_clamped[1] = clamp_digit(SW[7:4],   TENS_MAX);
      sw_clamped[2] = clamp_digit(SW[11:8],  UNITS_MAX);
      sw_clamped[3] = clamp_digit(SW[15:12], TENS_MAX);
   end

   assign tick = (state_q == RUN) && (presc_q == TICK_LAST);

   bcd_down_digit u_sec_units (.value_i(digit_q[0]), .dec_en_i(tick),      .max_i(UNITS_MAX),
                               .next_o(digit_d[0]),  .borrow_o(borrow[0]));
   bcd_down_digit u_sec_tens  (.value_i(digit_q[1]), .dec_en_i(borrow[0]), .max_i(TENS_MAX),
                               .next_o(digit_d[1]),  .borrow_o(borrow[1]));
   bcd_down_digit u_min_units (.value_i(digit_q[2]), .dec_en_i(borrow[1]), .max_i(UNITS_MAX),
                               .next_o(digit_d[2]),  .borrow_o(borrow[2]));
   // RUN is only ever entered with a non-zero value, so the top borrow never fires.
   bcd_down_digit u_min_tens  (.value_i(digit_q[3]), .dec_en_i(borrow[2]), .max_i(TENS_MAX),
                               .next_o(digit_d[3]),  .borrow_o(unused_top_borrow));

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         digit_q <= '0;
         presc_q <= '0;
         led_q   <= 1'b0;
      end else if (press[0]) begin
         state_q <= IDLE;
         digit_q <= sw_clamped;
         presc_q <= '0;
         led_q   <= 1'b0;
      end else if (press[1]) begin
         case (state_q)
            IDLE: begin
               if (digit_q != '0) begin
                  state_q <= RUN;
                  presc_q <= '0;
               end
            end
            RUN:   state_q <= PAUSE;
            PAUSE: state_q <= RUN;
            DONE: begin
               state_q <= IDLE;
               led_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end else if (state_q == RUN) begin
         if (tick) begin
            presc_q <= '0;
            digit_q <= digit_d;
            if (digit_d == '0) begin
               state_q <= DONE;
               led_q   <= 1'b1;
            end
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   assign LEDR = led_q;

`ifdef COUNTDOWN_BLINK_EN
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] blink_cnt_q;
   logic          blink_off_q;

   // Held clear outside DONE, so every expiry starts with the digits visible.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else if (state_q != DONE) begin
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_q <= '0;
         blink_off_q <= ~blink_off_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BW'(1);
      end
   end

   wire blank = (state_q == DONE) && blink_off_q;
`else
   logic unused_blink_div;
   assign unused_blink_div = |BLINK_DIV;
   wire blank = 1'b0;
`endif

   always_comb begin
      HEX0 = blank ? SEG_BLANK : seg_decode(digit_q[0]);
      HEX1 = blank ? SEG_BLANK : seg_decode(digit_q[1]);
      HEX2 = blank ? SEG_BLANK : seg_decode(digit_q[2]);
      HEX3 = blank ? SEG_BLANK : seg_decode(digit_q[3]);
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=10, BLINK_DIV=4; checks the displays
// and LEDR against hand-derived mm:ss values (blink checks compile in with COUNTDOWN_BLINK_EN).
module tb_countdown_timer;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  key   = 2'b11;
   logic [15:0] sw    = 16'h0000;
   logic [0:6]  hex0, hex1, hex2, hex3;
   logic        ledr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   countdown_timer #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .KEY      (key),
      .SW       (sw),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .LEDR     (ledr)
   );

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [28:0] obs, input logic [28:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // bcd is {min_tens, min_units, sec_tens, sec_units}
   task automatic check_disp(input string tag, input logic [15:0] bcd, input logic led);
      check(tag, {hex3, hex2, hex1, hex0, ledr},
            {seg(bcd[15:12]), seg(bcd[11:8]), seg(bcd[7:4]), seg(bcd[3:0]), led});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; the press acts on the 3rd rising edge, so hold=3 returns just after it.
   task automatic press(input logic [1:0] mask, input int hold);
      key = ~mask;
      repeat (hold) @(negedge clk);
      key = 2'b11;
   endtask

   initial begin
      // 1: reset state, start at 00:00 ignored
      cyc(2);
      check_disp("reset", 16'h0000, 1'b0);
      rst_n = 1'b1;
      cyc(2);
      press(2'b10, 3);
      cyc(15);
      check_disp("start_at_zero_idle", 16'h0000, 1'b0);

      // 2: 00:12 countdown to expiry
      sw = 16'h0012;
      press(2'b01, 3);
      check_disp("load_0012", 16'h0012, 1'b0);
      press(2'b10, 3);
      cyc(9);
      check_disp("before_first_tick", 16'h0012, 1'b0);
      cyc(1);
      check_disp("first_tick", 16'h0011, 1'b0);
      cyc(109);
      check_disp("last_second", 16'h0001, 1'b0);
      cyc(1);
      check_disp("expired", 16'h0000, 1'b1);
`ifdef COUNTDOWN_BLINK_EN
      cyc(3);
      check_disp("blink_on_end", 16'h0000, 1'b1);
      cyc(1);
      check("blink_off", {hex3, hex2, hex1, hex0, ledr}, {28'hFFFFFFF, 1'b1});
      cyc(3);
      check("blink_off_end", {hex3, hex2, hex1, hex0, ledr}, {28'hFFFFFFF, 1'b1});
      cyc(1);
      check_disp("blink_on_again", 16'h0000, 1'b1);
      cyc(20);
      check("done_led_hold", {28'h0, ledr}, {28'h0, 1'b1});
`else
      cyc(8);
      check_disp("done_steady", 16'h0000, 1'b1);
      cyc(20);
      check_disp("no_wrap", 16'h0000, 1'b1);
`endif
      press(2'b10, 3);
      check_disp("ack_to_idle", 16'h0000, 1'b0);
      cyc(15);
      check_disp("idle_after_ack", 16'h0000, 1'b0);

      // 3: borrow chain
      sw = 16'h1000;
      press(2'b01, 3);
      press(2'b10, 3);
      cyc(9);
      check_disp("borrow_pre", 16'h1000, 1'b0);
      cyc(1);
      check_disp("borrow_1000", 16'h0959, 1'b0);
      sw = 16'h0100;
      press(2'b01, 3);
      cyc(12);
      check_disp("load_in_run_idles", 16'h0100, 1'b0);
      press(2'b10, 3);
      cyc(10);
      check_disp("borrow_0100", 16'h0059, 1'b0);

      // 4: pause at prescaler 6 with a long hold, resume mid-second
      sw = 16'h0005;
      press(2'b01, 3);
      press(2'b10, 3);
      cyc(4);
      press(2'b10, 50);
      check_disp("paused_hold", 16'h0005, 1'b0);
      cyc(5);
      check_disp("paused_release", 16'h0005, 1'b0);
      press(2'b10, 3);
      cyc(3);
      check_disp("resume_pre", 16'h0005, 1'b0);
      cyc(1);
      check_disp("resume_tick", 16'h0004, 1'b0);

      // 5: clamp and same-cycle load/start
      sw = 16'h7A8F;
      press(2'b11, 3);
      check_disp("clamp_load", 16'h5959, 1'b0);
      cyc(15);
      check_disp("collision_idle", 16'h5959, 1'b0);

      // 6: asynchronous reset while running
      sw = 16'h0037;
      press(2'b01, 3);
      press(2'b10, 3);
      cyc(12);
      check_disp("run_0037", 16'h0036, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_disp("async_reset", 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(15);
      check_disp("post_reset_idle", 16'h0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
